// File: rtl/uart_prog_loader.sv
// Boot-time program loader. A programming-button edge holds the core in reset
// and streams a UART image into instruction memory as little-endian 32-bit
// words. The core is released when the end-of-image marker word arrives.
//
// Top FSM
//   state | meaning
//   IDLE  | waiting for a prog edge, core running
//   LOAD  | assembling bytes from the holding register into a word
//   WRITE | memory write pending, we_o held until gnt_i
//   DONE  | image complete, core released, prog edge restarts
//
// UART receiver FSM
//   state   | meaning
//   R_IDLE  | line idle, waiting for a low level
//   R_START | counting to mid start bit to reject glitches
//   R_DATA  | sampling 8 data bits LSB first at mid bit
//   R_STOP  | sampling the stop bit
module uart_prog_loader #(
    parameter int          ADDR_W   = 13,
    parameter logic [31:0] END_WORD = 32'h0000_0FFF
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              prog_i,
    input  logic              rx_i,
    input  logic [15:0]       clks_per_bit_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [31:0]       wdata_o,
    input  logic              gnt_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              frame_err_o,
    output logic              overrun_o,
    output logic              core_rst_no
);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    state_t      state;
    rx_state_t   r_state;

    logic        prog_s1, prog_s2, prog_d;
    logic        rx_s1, rx_s2;
    logic        prog_edge;

    logic [15:0] cpb_eff;
    logic [15:0] r_cpb;
    logic [15:0] r_cnt;
    logic [2:0]  r_bits;
    logic [7:0]  r_shift;
    logic        rx_valid;
    logic [7:0]  rx_byte;

    logic        hold_full;
    logic [7:0]  hold_data;
    logic [23:0] word_lo;
    logic [1:0]  byte_cnt;
    logic [31:0] full_word;

    assign prog_edge = prog_s2 & ~prog_d;
    assign cpb_eff   = (clks_per_bit_i < 16'd2) ? 16'd2 : clks_per_bit_i;
    assign full_word = {hold_data, word_lo};

    // Two-flop synchronizers for the asynchronous pads, plus the prog edge register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            prog_s1 <= 1'b0;
            prog_s2 <= 1'b0;
            prog_d  <= 1'b0;
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
        end else begin
            prog_s1 <= prog_i;
            prog_s2 <= prog_s1;
            prog_d  <= prog_s2;
            rx_s1   <= rx_i;
            rx_s2   <= rx_s1;
        end
    end

    // UART receiver: mid-bit sampling with a down-counter reloaded from the latched divisor.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= R_IDLE;
            r_cpb       <= 16'd0;
            r_cnt       <= 16'd0;
            r_bits      <= 3'd0;
            r_shift     <= 8'd0;
            rx_valid    <= 1'b0;
            rx_byte     <= 8'd0;
            frame_err_o <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            frame_err_o <= 1'b0;
            case (r_state)
                R_IDLE: begin
                    if (!rx_s2) begin
                        r_cpb   <= cpb_eff;
                        r_cnt   <= (cpb_eff >> 1) - 16'd1;
                        r_bits  <= 3'd0;
                        r_state <= R_START;
                    end
                end
                R_START: begin
                    if (r_cnt == 16'd0) begin
                        if (!rx_s2) begin
                            r_cnt   <= r_cpb - 16'd1;
                            r_state <= R_DATA;
                        end else begin
                            r_state <= R_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                R_DATA: begin
                    if (r_cnt == 16'd0) begin
                        r_shift <= {rx_s2, r_shift[7:1]};
                        r_cnt   <= r_cpb - 16'd1;
                        if (r_bits == 3'd7) begin
                            r_state <= R_STOP;
                        end else begin
                            r_bits <= r_bits + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                R_STOP: begin
                    if (r_cnt == 16'd0) begin
                        if (rx_s2) begin
                            rx_valid <= 1'b1;
                            rx_byte  <= r_shift;
                        end else begin
                            frame_err_o <= 1'b1;
                        end
                        r_state <= R_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Loader FSM with the one-byte holding register between receiver and word assembly.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            we_o        <= 1'b0;
            addr_o      <= '0;
            wdata_o     <= 32'd0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            overrun_o   <= 1'b0;
            core_rst_no <= 1'b0;
            hold_full   <= 1'b0;
            hold_data   <= 8'd0;
            word_lo     <= 24'd0;
            byte_cnt    <= 2'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    core_rst_no <= 1'b1;
                    busy_o      <= 1'b0;
                    if (prog_edge) begin
                        state       <= LOAD;
                        addr_o      <= '0;
                        byte_cnt    <= 2'd0;
                        overrun_o   <= 1'b0;
                        hold_full   <= 1'b0;
                        we_o        <= 1'b0;
                        busy_o      <= 1'b1;
                        done_o      <= 1'b0;
                        core_rst_no <= 1'b0;
                    end
                end
                LOAD: begin
                    if (hold_full) begin
                        hold_full <= 1'b0;
                        byte_cnt  <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: word_lo[7:0]   <= hold_data;
                            2'd1: word_lo[15:8]  <= hold_data;
                            2'd2: word_lo[23:16] <= hold_data;
                            default: begin
                                if (full_word == END_WORD) begin
                                    state       <= DONE;
                                    done_o      <= 1'b1;
                                    busy_o      <= 1'b0;
                                    core_rst_no <= 1'b1;
                                end else begin
                                    state   <= WRITE;
                                    wdata_o <= full_word;
                                    we_o    <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                WRITE: begin
                    if (gnt_i) begin
                        we_o   <= 1'b0;
                        addr_o <= addr_o + 1'b1;
                        state  <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase

            // A byte landing in the same cycle LOAD drains the register is still taken.
            if (rx_valid && (state == LOAD || state == WRITE)) begin
                if (hold_full && state != LOAD) begin
                    overrun_o <= 1'b1;
                end else begin
                    hold_data <= rx_byte;
                    hold_full <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed-sequence bench for uart_prog_loader with randomized image words.
// Expected writes come from a byte-stream model: accepted bytes are grouped
// four at a time into little-endian words, stopping at the end marker.
module tb_uart_prog_loader;

    localparam logic [31:0] END_W = 32'h0000_0FFF;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        prog_i   = 1'b0;
    logic        rx_i     = 1'b1;
    logic        gnt_i    = 1'b0;
    logic [15:0] clks_per_bit_i = 16'd4;

    logic        we_o;
    logic [12:0] addr_o;
    logic [31:0] wdata_o;
    logic        busy_o, done_o, frame_err_o, overrun_o, core_rst_no;

    uart_prog_loader dut (
        .wb_clk_i       (wb_clk_i),
        .wb_rst_i       (wb_rst_i),
        .prog_i         (prog_i),
        .rx_i           (rx_i),
        .clks_per_bit_i (clks_per_bit_i),
        .we_o           (we_o),
        .addr_o         (addr_o),
        .wdata_o        (wdata_o),
        .gnt_i          (gnt_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .frame_err_o    (frame_err_o),
        .overrun_o      (overrun_o),
        .core_rst_no    (core_rst_no)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        logic [12:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t        got_q[$];
    logic [7:0] exp_bytes[$];
    int         fe_cnt  = 0;
    int         n_pass  = 0;
    int         n_total = 0;

    // Record completed writes and frame-error pulses away from the active edge.
    always @(negedge wb_clk_i) begin
        if (!wb_rst_i && we_o && gnt_i) got_q.push_back('{a: addr_o, d: wdata_o});
        if (frame_err_o) fe_cnt++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge wb_clk_i);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int bit_cyc);
        rx_i = 1'b0;
        step(bit_cyc);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            step(bit_cyc);
        end
        rx_i = stop_bit;
        step(bit_cyc);
        rx_i = 1'b1;
        step(bit_cyc + 2);
    endtask

    task automatic send_word(input logic [31:0] w, input int bit_cyc, input logic accepted);
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            b = w[8*i +: 8];
            send_byte(b, 1'b1, bit_cyc);
            if (accepted) exp_bytes.push_back(b);
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        do w = $urandom; while (w == END_W);
        return w;
    endfunction

    task automatic pulse_prog(input string tag);
        int c;
        prog_i = 1'b1;
        step(4);
        prog_i = 1'b0;
        c = 0;
        while (!busy_o && c < 10) begin
            step(1);
            c++;
        end
        chk($sformatf("%s_busy", tag), busy_o, 1);
        chk($sformatf("%s_core_rst", tag), core_rst_no, 0);
        chk($sformatf("%s_addr0", tag), addr_o, 0);
    endtask

    task automatic wait_done(input string tag, input int lim);
        int c = 0;
        while (!done_o && c < lim) begin
            step(1);
            c++;
        end
        chk($sformatf("%s_done", tag), done_o, 1);
        chk($sformatf("%s_core_rel", tag), core_rst_no, 1);
        chk($sformatf("%s_busy0", tag), busy_o, 0);
    endtask

    task automatic wait_we(input string tag, input int lim);
        int c = 0;
        while (!we_o && c < lim) begin
            step(1);
            c++;
        end
        chk($sformatf("%s_we", tag), we_o, 1);
    endtask

    // Reference model: accepted byte stream -> expected sequential writes.
    task automatic check_writes(input string tag);
        logic [31:0] exp_w[$];
        logic [31:0] w;
        int          n;
        for (int i = 0; i + 3 < exp_bytes.size(); i += 4) begin
            w = {exp_bytes[i+3], exp_bytes[i+2], exp_bytes[i+1], exp_bytes[i]};
            if (w == END_W) break;
            exp_w.push_back(w);
        end
        chk($sformatf("%s_nwrites", tag), got_q.size(), exp_w.size());
        n = (got_q.size() < exp_w.size()) ? got_q.size() : exp_w.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), got_q[i].a, i);
            chk($sformatf("%s_data%0d", tag, i), got_q[i].d, exp_w[i]);
        end
        got_q.delete();
        exp_bytes.delete();
    endtask

    initial begin
        logic [31:0] hold_d;
        logic [12:0] hold_a;
        logic        stable;
        logic [31:0] w;
        int          cpb;
        int          fe_before;

        // Reset state
        step(3);
        chk("rst_we", we_o, 0);
        chk("rst_core", core_rst_no, 0);
        chk("rst_busy", busy_o, 0);
        wb_rst_i = 1'b0;
        step(1);
        chk("rel_core", core_rst_no, 1);
        chk("rel_done", done_o, 0);

        // Single word with grant held high
        gnt_i = 1'b1;
        clks_per_bit_i = 16'd4;
        pulse_prog("single");
        send_word(32'h1234_5678, 4, 1'b1);
        send_word(END_W, 4, 1'b1);
        wait_done("single", 50);
        check_writes("single");

        // Grant stall then three more words at a random divisor
        cpb = $urandom_range(3, 6);
        clks_per_bit_i = 16'(cpb);
        gnt_i = 1'b0;
        pulse_prog("stall");
        send_word(rand_word(), cpb, 1'b1);
        wait_we("stall", 20);
        hold_a = addr_o;
        hold_d = wdata_o;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (!we_o || addr_o != hold_a || wdata_o != hold_d) stable = 1'b0;
        end
        chk("stall_stable", stable, 1);
        chk("stall_nowrite", got_q.size(), 0);
        gnt_i = 1'b1;
        step(2);
        chk("stall_we_drop", we_o, 0);
        for (int i = 0; i < 3; i++) send_word(rand_word(), cpb, 1'b1);
        send_word(END_W, cpb, 1'b1);
        wait_done("stall", 50);
        check_writes("stall");

        // Frame error then a good word
        clks_per_bit_i = 16'd4;
        pulse_prog("ferr");
        fe_before = fe_cnt;
        send_byte(8'h55, 1'b0, 4);
        step(6);
        chk("ferr_pulse", fe_cnt - fe_before, 1);
        send_word(rand_word(), 4, 1'b1);
        send_word(END_W, 4, 1'b1);
        wait_done("ferr", 50);
        check_writes("ferr");

        // Glitch at cpb=16, then decode with cpb=0 treated as 2
        clks_per_bit_i = 16'd16;
        pulse_prog("glitch");
        fe_before = fe_cnt;
        rx_i = 1'b0;
        step(1);
        rx_i = 1'b1;
        step(40);
        chk("glitch_noferr", fe_cnt - fe_before, 0);
        clks_per_bit_i = 16'd0;
        send_word(rand_word(), 2, 1'b1);
        send_word(rand_word(), 2, 1'b1);
        send_word(END_W, 2, 1'b1);
        wait_done("cpb0", 50);
        check_writes("cpb0");

        // Overrun: two bytes arrive while the write is stalled
        clks_per_bit_i = 16'd4;
        gnt_i = 1'b0;
        pulse_prog("ovr");
        send_word(rand_word(), 4, 1'b1);
        wait_we("ovr", 20);
        w = rand_word();
        send_byte(w[7:0], 1'b1, 4);
        exp_bytes.push_back(w[7:0]);
        chk("ovr_not_yet", overrun_o, 0);
        send_byte(w[15:8], 1'b1, 4);
        chk("ovr_set", overrun_o, 1);
        gnt_i = 1'b1;
        step(3);
        w = rand_word();
        for (int i = 1; i < 4; i++) begin
            send_byte(w[8*i +: 8], 1'b1, 4);
            exp_bytes.push_back(w[8*i +: 8]);
        end
        send_word(END_W, 4, 1'b1);
        wait_done("ovr", 50);
        chk("ovr_sticky", overrun_o, 1);
        check_writes("ovr");

        // New load clears overrun; reset mid-write aborts
        gnt_i = 1'b0;
        pulse_prog("rst");
        chk("rst_ovr_clear", overrun_o, 0);
        send_word(rand_word(), 4, 1'b0);
        wait_we("rstw", 20);
        wb_rst_i = 1'b1;
        step(1);
        chk("mid_we", we_o, 0);
        chk("mid_addr", addr_o, 0);
        chk("mid_wdata", wdata_o, 0);
        chk("mid_busy", busy_o, 0);
        chk("mid_done", done_o, 0);
        chk("mid_ferr", frame_err_o, 0);
        chk("mid_ovr", overrun_o, 0);
        chk("mid_core", core_rst_no, 0);
        wb_rst_i = 1'b0;
        step(1);
        chk("post_core", core_rst_no, 1);
        gnt_i = 1'b1;
        got_q.delete();
        send_word(rand_word(), 4, 1'b0);
        step(5);
        chk("post_idle_busy", busy_o, 0);
        chk("post_idle_we", we_o, 0);
        chk("post_idle_nowrite", got_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

Boot-time program loader sitting directly upstream of the SoC core and its instruction memory. On a rising edge of the programming button, it holds the core in reset and receives a program image over the UART RX pad using the runtime baud divisor from the logic-analyzer bus. It assembles the bytes into little-endian 32-bit words and writes them sequentially into instruction memory through a request/grant port. It releases the core when the end-of-image marker word arrives.

## Interface
Parameters:
- ADDR_W, 13: word-address width of the instruction-memory port.
- END_WORD, 32'h0000_0FFF: end-of-image marker. It is never written to memory.

Ports:
- wb_clk_i  in  1  single clock for the whole block.
- wb_rst_i  in  1  reset, synchronous, active-high.
- prog_i  in  1  programming button, asynchronous to the clock.
- rx_i  in  1  UART RX line (8N1), asynchronous; idles high.
- clks_per_bit_i  in  16  clock cycles per UART bit; values below 2 are treated as 2.
- we_o  out  1  memory write request, held until granted.
- addr_o  out  ADDR_W  word address of the current write.
- wdata_o  out  32  write data.
- gnt_i  in  1  memory accepts the write in any cycle where we_o and gnt_i are both 1.
- busy_o  out  1  1 while loading, from entry into LOAD until DONE.
- done_o  out  1  1 in DONE.
- frame_err_o  out  1  one-cycle pulse when a byte's stop bit samples 0.
- overrun_o  out  1  sticky flag; cleared on reset and on each new load.
- core_rst_no  out  1  active-low reset to the core.

## Operation
- Synchronizers: prog_i and rx_i each pass through a 2-flop synchronizer. A load starts on a synchronized prog_i 0->1 edge.

Top FSM, states IDLE, LOAD, WRITE, DONE:
- IDLE: core_rst_no=1. A prog edge moves to LOAD and does the following:
  - clears addr_o to 0, the byte count and overrun_o;
  - drives core_rst_no=0.
- LOAD: consumes received bytes.
  - byte n (n=0..3) goes into word bits [8n+7:8n];
  - after the 4th byte, if word==END_WORD, go to DONE; otherwise go to WRITE with we_o=1.
- WRITE: we_o, addr_o and wdata_o stay stable until gnt_i. In the grant cycle:
  - we_o goes to 0 the next cycle;
  - addr_o increments, wrapping from 2^ADDR_W-1 to 0;
  - the FSM returns to LOAD.
- DONE: done_o=1, core_rst_no=1, busy_o=0. A prog edge restarts LOAD.
- A prog edge in LOAD or WRITE is ignored.

UART receiver, states R_IDLE, R_START, R_DATA, R_STOP (runs continuously):
- R_IDLE: a synchronized rx of 0 moves to R_START with the bit counter cleared.
- R_START: waits cpb/2 cycles (floor), then resamples rx.
  - 0: go to R_DATA;
  - 1: glitch, return to R_IDLE.
- R_DATA: samples rx every cpb cycles, 8 bits, LSB first.
- R_STOP: samples rx after cpb cycles.
  - 1: the byte is valid;
  - 0: pulse frame_err_o and discard the byte.
  - Either way, return to R_IDLE.
- Byte hand-off:
  - A valid byte completed while the FSM is in IDLE or DONE is dropped.
  - A valid byte completed in LOAD or WRITE goes into a 1-byte holding register. LOAD drains it the cycle after it is captured.
  - If a new byte completes while the holding register is still full, overrun_o is set and the new byte is dropped.
- clks_per_bit_i is sampled at each start-bit detection. It is held constant for the rest of that frame.

## Timing
- Reset values (synchronous reset, effective on the clock edge while wb_rst_i=1):
  - 0: we_o, addr_o, wdata_o, busy_o, done_o, frame_err_o, overrun_o, core_rst_no;
  - FSMs go to IDLE and R_IDLE.
  - The first cycle after reset release (IDLE), core_rst_no=1.
- All outputs are registered.
- prog edge to LOAD/busy_o=1/core_rst_no=0: 3 cycles (2 synchronizer flops plus the edge register).
- rx falling edge to detection: 2 cycles of synchronizer delay.
- Byte valid: 2 + cpb/2 + 9*cpb cycles (±1) after the rx falling edge.
- 4th byte into holding register to we_o=1: 2 cycles.
- we_o stays high for at least 1 cycle. A grant in the first cycle gives a 1-cycle write.
- Grant to the next we_o: at least 4 byte-times later.
- END_WORD complete to done_o=1 and core_rst_no=1: 2 cycles.
- A byte arriving in the same cycle as gnt_i is captured normally, with no loss.
- Reset asserted mid-load aborts the load: the partial word is discarded and we_o drops to 0 on that edge.

## Test plan
- Single word: cpb=4; prog edge; send bytes 0x78,0x56,0x34,0x12, then 0xFF,0x0F,0x00,0x00; gnt_i held at 1.
  - Expect exactly one write: addr 0, data 0x12345678.
  - Then done_o=1 and core_rst_no=1; no write of 0x00000FFF.
- Grant stall: same image with gnt_i=0 for 20 cycles.
  - we_o, addr_o and wdata_o must stay stable throughout; one write on grant.
  - Then send 3 more words: addresses 1, 2, 3 in order.
- Frame error: send 0x55 with the stop bit forced to 0.
  - Expect a frame_err_o pulse and no byte counted.
  - The next 4 good bytes form word 0 correctly.
- Glitch and divisor: a 1-cycle low pulse on rx (cpb=16) gives no byte.
  - With cpb=0, bytes decode as cpb=2.
- Overrun: hold gnt_i=0 while 2 more bytes arrive.
  - Expect overrun_o=1 and the second byte dropped.
  - A new prog edge after DONE clears overrun_o and restarts at address 0.
- Reset mid-write: assert wb_rst_i while we_o=1.
  - Next cycle: all outputs 0.
  - After release: core_rst_no=1, and the block is idle until a prog edge.
